core_id_issue: RTL and testbench

- Issue stage directly upstream of the execute unit. Holds one decoded instruction in a pipeline register and reads the register file.
- Resolves RAW hazards by forwarding from EX and writeback, or by stalling. Presents operands and instruction buses to EX with a valid/ready handshake.
- Drops its held instruction on a commit flush.

---
 rtl/core_id_issue_pkg.sv | 9 +
 rtl/core_id_fwd_mux.sv | 28 ++
 rtl/core_id_issue.sv | 138 +++++++++++++
 tb/tb_core_id_issue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_id_issue_pkg.sv
// core_id_issue_pkg: core-wide widths shared by the issue stage and its bench
package core_id_issue_pkg;
  localparam int CORE_XLEN              = 32;
  localparam int CORE_PC_WIDTH          = 32;
  localparam int CORE_RFIDX_WIDTH       = 5;
  localparam int CORE_BJ_DEC_INST_WIDTH = 17;
  localparam int CORE_ALU_INST_WIDTH    = 21;
  localparam int CORE_LSU_INST_WIDTH    = 13;
endpackage

// File: rtl/core_id_fwd_mux.sv
// core_id_fwd_mux: per-operand forwarding select and load-use hazard detect
module core_id_fwd_mux
  import core_id_issue_pkg::*;
#(
  parameter int XLEN    = CORE_XLEN,
  parameter int RFIDX_W = CORE_RFIDX_WIDTH
) (
  input  logic               vld_i,
  input  logic               ren_i,
  input  logic [RFIDX_W-1:0] idx_i,
  input  logic [XLEN-1:0]    rf_dat_i,
  input  logic [RFIDX_W-1:0] ex_rd_idx_i,
  input  logic               ex_rd_wen_i,
  input  logic               ex_busy_i,
  input  logic [XLEN-1:0]    ex_rd_dat_i,
  input  logic               wb_en_i,
  input  logic [RFIDX_W-1:0] wb_idx_i,
  input  logic [XLEN-1:0]    wb_data_i,
  output logic [XLEN-1:0]    dat_o,
  output logic               hazard_o
);
  logic nz, ex_hit, wb_hit;
  assign nz       = |idx_i;
  assign ex_hit   = ex_rd_wen_i & (ex_rd_idx_i == idx_i);
  assign wb_hit   = wb_en_i & (wb_idx_i == idx_i);
  assign dat_o    = !nz ? '0 : (ex_hit & ~ex_busy_i) ? ex_rd_dat_i : wb_hit ? wb_data_i : rf_dat_i;
  assign hazard_o = vld_i & ren_i & nz & ex_hit & ex_busy_i;
endmodule

// File: rtl/core_id_issue.sv
// core_id_issue: one-entry issue register with operand forwarding, hazard stall and flush
module core_id_issue
  import core_id_issue_pkg::*;
#(
  parameter int XLEN    = CORE_XLEN,
  parameter int PC_W    = CORE_PC_WIDTH,
  parameter int RFIDX_W = CORE_RFIDX_WIDTH,
  parameter int BJ_W    = CORE_BJ_DEC_INST_WIDTH,
  parameter int ALU_W   = CORE_ALU_INST_WIDTH,
  parameter int LSU_W   = CORE_LSU_INST_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [PC_W-1:0]    i_pc,
  input  logic               i_branch_predict,
  input  logic [XLEN-1:0]    i_imm,
  input  logic               i_rs1_ren,
  input  logic               i_rs2_ren,
  input  logic               i_rd_wen,
  input  logic [RFIDX_W-1:0] i_rs1_idx,
  input  logic [RFIDX_W-1:0] i_rs2_idx,
  input  logic [RFIDX_W-1:0] i_rd_idx,
  input  logic [BJ_W-1:0]    i_bj_bus,
  input  logic [ALU_W-1:0]   i_alu_bus,
  input  logic [LSU_W-1:0]   i_lsu_bus,
  output logic [RFIDX_W-1:0] rf_rs1_idx,
  output logic [RFIDX_W-1:0] rf_rs2_idx,
  input  logic [XLEN-1:0]    rf_rs1_dat,
  input  logic [XLEN-1:0]    rf_rs2_dat,
  input  logic [RFIDX_W-1:0] ex_rd_idx,
  input  logic               ex_rd_wen,
  input  logic [XLEN-1:0]    ex_rd_dat,
  input  logic               ex_busy,
  input  logic               wb_en,
  input  logic [RFIDX_W-1:0] wb_idx,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               flush_req,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_branch_predict,
  output logic [XLEN-1:0]    o_imm,
  output logic [XLEN-1:0]    o_rs1_dat,
  output logic [XLEN-1:0]    o_rs2_dat,
  output logic               o_rs1_ren,
  output logic               o_rs2_ren,
  output logic               o_rd_wen,
  output logic [RFIDX_W-1:0] o_rs1_idx,
  output logic [RFIDX_W-1:0] o_rs2_idx,
  output logic [RFIDX_W-1:0] o_rd_idx,
  output logic [BJ_W-1:0]    o_bj_bus,
  output logic [ALU_W-1:0]   o_alu_bus,
  output logic [LSU_W-1:0]   o_lsu_bus,
  output logic [31:0]        stall_cnt
);
  logic               valid_q, valid_d;
  logic [31:0]        stall_q, stall_d;
  logic [PC_W-1:0]    pc_q;
  logic               bp_q, rs1_ren_q, rs2_ren_q, rd_wen_q;
  logic [XLEN-1:0]    imm_q;
  logic [RFIDX_W-1:0] rs1_idx_q, rs2_idx_q, rd_idx_q;
  logic [BJ_W-1:0]    bj_q;
  logic [ALU_W-1:0]   alu_q;
  logic [LSU_W-1:0]   lsu_q;
  logic               haz1, haz2, hazard, fire_in, fire_out;
  core_id_fwd_mux #(.XLEN(XLEN), .RFIDX_W(RFIDX_W)) u_fwd1 (
    .vld_i(valid_q), .ren_i(rs1_ren_q), .idx_i(rs1_idx_q), .rf_dat_i(rf_rs1_dat),
    .ex_rd_idx_i(ex_rd_idx), .ex_rd_wen_i(ex_rd_wen), .ex_busy_i(ex_busy), .ex_rd_dat_i(ex_rd_dat),
    .wb_en_i(wb_en), .wb_idx_i(wb_idx), .wb_data_i(wb_data),
    .dat_o(o_rs1_dat), .hazard_o(haz1)
  );
  core_id_fwd_mux #(.XLEN(XLEN), .RFIDX_W(RFIDX_W)) u_fwd2 (
    .vld_i(valid_q), .ren_i(rs2_ren_q), .idx_i(rs2_idx_q), .rf_dat_i(rf_rs2_dat),
    .ex_rd_idx_i(ex_rd_idx), .ex_rd_wen_i(ex_rd_wen), .ex_busy_i(ex_busy), .ex_rd_dat_i(ex_rd_dat),
    .wb_en_i(wb_en), .wb_idx_i(wb_idx), .wb_data_i(wb_data),
    .dat_o(o_rs2_dat), .hazard_o(haz2)
  );
  assign hazard    = haz1 | haz2;
  assign valid_out = valid_q & ~hazard & ~flush_req;
  assign fire_out  = valid_out & ready_out;
  assign ready_in  = ~valid_q | fire_out;
  assign fire_in   = valid_in & ready_in;
  // an instruction accepted during a flush is loaded but never marked valid
  assign valid_d   = flush_req ? 1'b0 : fire_in ? 1'b1 : fire_out ? 1'b0 : valid_q;
  assign stall_d   = stall_q + {31'd0, valid_q & hazard & ~flush_req};
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      stall_q   <= '0;
      pc_q      <= '0;
      bp_q      <= 1'b0;
      imm_q     <= '0;
      rs1_ren_q <= 1'b0;
      rs2_ren_q <= 1'b0;
      rd_wen_q  <= 1'b0;
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
      rd_idx_q  <= '0;
      bj_q      <= '0;
      alu_q     <= '0;
      lsu_q     <= '0;
    end else begin
      valid_q <= valid_d;
      stall_q <= stall_d;
      if (fire_in) begin
        pc_q      <= i_pc;
        bp_q      <= i_branch_predict;
        imm_q     <= i_imm;
        rs1_ren_q <= i_rs1_ren;
        rs2_ren_q <= i_rs2_ren;
        rd_wen_q  <= i_rd_wen;
        rs1_idx_q <= i_rs1_idx;
        rs2_idx_q <= i_rs2_idx;
        rd_idx_q  <= i_rd_idx;
        bj_q      <= i_bj_bus;
        alu_q     <= i_alu_bus;
        lsu_q     <= i_lsu_bus;
      end
    end
  end
  assign rf_rs1_idx       = rs1_idx_q;
  assign rf_rs2_idx       = rs2_idx_q;
  assign o_pc             = pc_q;
  assign o_branch_predict = bp_q;
  assign o_imm            = imm_q;
  assign o_rs1_ren        = rs1_ren_q;
  assign o_rs2_ren        = rs2_ren_q;
  assign o_rd_wen         = rd_wen_q;
  assign o_rs1_idx        = rs1_idx_q;
  assign o_rs2_idx        = rs2_idx_q;
  assign o_rd_idx         = rd_idx_q;
  assign o_bj_bus         = bj_q;
  assign o_alu_bus        = alu_q;
  assign o_lsu_bus        = lsu_q;
  assign stall_cnt        = stall_q;
endmodule

// File: tb/tb_core_id_issue.sv
// tb_core_id_issue: directed vectors against a transaction-level model of the issue stage
module tb_core_id_issue;
  import core_id_issue_pkg::*;
  typedef struct packed {
    logic [31:0] pc;
    logic        bp;
    logic [31:0] imm;
    logic        r1en, r2en, rdwen;
    logic [4:0]  r1, r2, rd;
    logic [CORE_BJ_DEC_INST_WIDTH-1:0] bj;
    logic [CORE_ALU_INST_WIDTH-1:0]    alu;
    logic [CORE_LSU_INST_WIDTH-1:0]    lsu;
  } inst_t;
  logic clk = 0, rst = 1;
  logic valid_in = 0, ready_out = 0, flush_req = 0;
  inst_t cur = '0;
  logic [4:0]  ex_rd_idx = 0, wb_idx = 0;
  logic        ex_rd_wen = 0, ex_busy = 0, wb_en = 0;
  logic [31:0] ex_rd_dat = 0, wb_data = 0;
  logic [31:0] rf [32];
  logic        ready_in, valid_out, o_bp, o_r1en, o_r2en, o_rdwen;
  logic [4:0]  rf_rs1_idx, rf_rs2_idx, o_r1, o_r2, o_rd;
  logic [31:0] o_pc, o_imm, o_rs1_dat, o_rs2_dat, stall_cnt;
  logic [CORE_BJ_DEC_INST_WIDTH-1:0] o_bj;
  logic [CORE_ALU_INST_WIDTH-1:0]    o_alu;
  logic [CORE_LSU_INST_WIDTH-1:0]    o_lsu;
  int n_vec = 0, n_err = 0;
  core_id_issue dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .i_pc(cur.pc), .i_branch_predict(cur.bp), .i_imm(cur.imm),
    .i_rs1_ren(cur.r1en), .i_rs2_ren(cur.r2en), .i_rd_wen(cur.rdwen),
    .i_rs1_idx(cur.r1), .i_rs2_idx(cur.r2), .i_rd_idx(cur.rd),
    .i_bj_bus(cur.bj), .i_alu_bus(cur.alu), .i_lsu_bus(cur.lsu),
    .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx),
    .rf_rs1_dat(rf[rf_rs1_idx]), .rf_rs2_dat(rf[rf_rs2_idx]),
    .ex_rd_idx(ex_rd_idx), .ex_rd_wen(ex_rd_wen), .ex_rd_dat(ex_rd_dat), .ex_busy(ex_busy),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data), .flush_req(flush_req),
    .valid_out(valid_out), .ready_out(ready_out),
    .o_pc(o_pc), .o_branch_predict(o_bp), .o_imm(o_imm),
    .o_rs1_dat(o_rs1_dat), .o_rs2_dat(o_rs2_dat),
    .o_rs1_ren(o_r1en), .o_rs2_ren(o_r2en), .o_rd_wen(o_rdwen),
    .o_rs1_idx(o_r1), .o_rs2_idx(o_r2), .o_rd_idx(o_rd),
    .o_bj_bus(o_bj), .o_alu_bus(o_alu), .o_lsu_bus(o_lsu), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: one held transaction plus a stall counter
  logic        m_valid = 0;
  inst_t       m = '0;
  logic [31:0] m_stall = 0;
  function automatic logic [31:0] opnd(input logic [4:0] idx, input logic [31:0] rfv);
    if (idx == 0) return 0;
    if (ex_rd_wen && ex_rd_idx == idx && !ex_busy) return ex_rd_dat;
    if (wb_en && wb_idx == idx) return wb_data;
    return rfv;
  endfunction
  function automatic logic blocked();
    return m_valid && ex_rd_wen && ex_busy &&
           ((m.r1en && m.r1 != 0 && ex_rd_idx == m.r1) || (m.r2en && m.r2 != 0 && ex_rd_idx == m.r2));
  endfunction
  function automatic logic exp_vo();
    return m_valid && !blocked() && !flush_req;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 0;
      m       <= '0;
      m_stall <= 0;
    end else begin
      logic issued, taken;
      issued = exp_vo() && ready_out;
      taken  = valid_in && (!m_valid || issued);
      if (m_valid && blocked() && !flush_req) m_stall <= m_stall + 1;
      if (taken) m <= cur;
      m_valid <= flush_req ? 1'b0 : taken ? 1'b1 : issued ? 1'b0 : m_valid;
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_out", valid_out, exp_vo());
      chk("ready_in", ready_in, !m_valid || (exp_vo() && ready_out));
      chk("stall_cnt", stall_cnt, m_stall);
      if (m_valid) begin
        chk("rf_rs1_idx", rf_rs1_idx, m.r1);
        chk("rf_rs2_idx", rf_rs2_idx, m.r2);
        chk("o_fields", {o_pc, o_bp, o_imm, o_r1en, o_r2en, o_rdwen, o_r1, o_r2, o_rd, o_bj, o_alu, o_lsu},
            {m.pc, m.bp, m.imm, m.r1en, m.r2en, m.rdwen, m.r1, m.r2, m.rd, m.bj, m.alu, m.lsu});
        chk("o_rs1_dat", o_rs1_dat, opnd(m.r1, rf[m.r1]));
        chk("o_rs2_dat", o_rs2_dat, opnd(m.r2, rf[m.r2]));
      end
    end
  end
  function automatic inst_t mk(input logic [31:0] pc, input logic r1en, input logic [4:0] r1,
                               input logic r2en, input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] imm);
    inst_t t;
    t.pc = pc; t.bp = pc[2]; t.imm = imm;
    t.r1en = r1en; t.r2en = r2en; t.rdwen = 1'b1;
    t.r1 = r1; t.r2 = r2; t.rd = rd;
    t.bj = pc[16:0]; t.alu = {pc[10:0], imm[9:0]}; t.lsu = pc[12:0] ^ 13'h1A5;
    return t;
  endfunction
  task automatic step(); @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); #1; endtask
  initial begin
    logic [31:0] held_pc;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hDEAD_BEEF;
    step(); step();
    rst = 0;
    look();
    chk("rst_valid_out", valid_out, 0);
    chk("rst_ready_in", ready_in, 1);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_rd_wen", o_rdwen, 0);
    // addi x1, x0, 5
    step();
    cur = mk(32'h100, 1, 0, 0, 0, 1, 5); valid_in = 1; ready_out = 1;
    step();
    valid_in = 0;
    look();
    chk("addi_valid", valid_out, 1);
    chk("addi_rs1", o_rs1_dat, 0);
    chk("addi_imm", o_imm, 5);
    step();
    // four back-to-back instructions
    for (int k = 0; k < 4; k++) begin
      cur = mk(32'h200 + 4 * k, 1, 5'(6 + k), 1, 5'(10 + k), 5'(20 + k), 32'(k * 3));
      valid_in = 1;
      look();
      chk("b2b_ready_in", ready_in, 1);
      if (k > 0) chk("b2b_valid_out", valid_out, 1);
      step();
    end
    valid_in = 0;
    look();
    chk("b2b_last_valid", valid_out, 1);
    chk("b2b_last_rs1", o_rs1_dat, 32'h1009);
    step();
    // EX forwarding beats WB
    rf[3] = 32'h11;
    cur = mk(32'h300, 1, 3, 0, 0, 7, 0); valid_in = 1; ready_out = 0;
    step();
    valid_in = 0; ex_rd_idx = 3; ex_rd_wen = 1; ex_busy = 0; ex_rd_dat = 32'hAA;
    look();
    chk("ex_fwd", o_rs1_dat, 32'hAA);
    wb_en = 1; wb_idx = 3; wb_data = 32'hBB;
    look();
    chk("ex_over_wb", o_rs1_dat, 32'hAA);
    ex_rd_wen = 0;
    look();
    chk("wb_fwd", o_rs1_dat, 32'hBB);
    wb_en = 0;
    look();
    chk("rf_read", o_rs1_dat, 32'h11);
    ready_out = 1;
    step();
    // load-use stall on rs2
    cur = mk(32'h400, 1, 2, 1, 5, 8, 0); valid_in = 1;
    step();
    valid_in = 0; ex_rd_idx = 5; ex_rd_wen = 1; ex_busy = 1; ex_rd_dat = 32'h55;
    for (int k = 0; k < 3; k++) begin
      look();
      chk("stall_valid_out", valid_out, 0);
      chk("stall_ready_in", ready_in, 0);
      step();
    end
    ex_busy = 0;
    look();
    chk("stall_cnt3", stall_cnt, 3);
    chk("stall_release", valid_out, 1);
    chk("stall_fwd", o_rs2_dat, 32'h55);
    step();
    ex_rd_wen = 0;
    // backpressure
    ready_out = 0;
    cur = mk(32'h500, 1, 4, 1, 9, 12, 32'h77); valid_in = 1;
    step();
    held_pc = 32'h500;
    cur = mk(32'h504, 1, 1, 0, 0, 13, 1);
    for (int k = 0; k < 4; k++) begin
      look();
      chk("bp_ready_in", ready_in, 0);
      chk("bp_pc", o_pc, held_pc);
      step();
    end
    valid_in = 0; ready_out = 1;
    look();
    chk("bp_release", valid_out, 1);
    step();
    look();
    chk("bp_single", valid_out, 0);
    // flush drops held and incoming instructions
    cur = mk(32'h600, 1, 1, 1, 2, 3, 0); valid_in = 1;
    step();
    cur = mk(32'h604, 1, 1, 1, 2, 3, 0); flush_req = 1;
    look();
    chk("flush_valid_out", valid_out, 0);
    step();
    flush_req = 0; valid_in = 0;
    look();
    chk("post_flush_valid", valid_out, 0);
    chk("post_flush_ready", ready_in, 1);
    cur = mk(32'h608, 0, 0, 0, 0, 3, 9); valid_in = 1;
    step();
    valid_in = 0;
    look();
    chk("post_flush_issue", valid_out, 1);
    chk("post_flush_pc", o_pc, 32'h608);
    step();
    // reset during a stall
    cur = mk(32'h700, 1, 6, 0, 0, 1, 0); valid_in = 1;
    step();
    valid_in = 0; ex_rd_idx = 6; ex_rd_wen = 1; ex_busy = 1;
    step(); step();
    rst = 1;
    step();
    rst = 0; ex_rd_wen = 0; ex_busy = 0;
    look();
    chk("rst_stall_valid", valid_out, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_stall_ready", ready_in, 1);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
